mips_exec_unit: RTL and testbench
=================================

Name: mips_exec_unit

Overview:
- Execute-stage datapath slice of the single-cycle MIPS-I Harvard CPU.
- Combinational parts: ALU-control decode, the 32-bit ALU with a HI/LO multiply/divide result, and next-PC target selection.
- Registered part: a one-entry delay-slot redirect (target plus pending flag), so taken branches and jumps take effect after the delay-slot instruction.
- Sits between the main control/register file and the PC register.

Parameters:
- None. The datapath width is fixed at 32 bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clk_enable  in  1  when low, the registered state holds its value.
- alu_op  in  2  00 add (load/store), 01 subtract (branch compare), 10 R-type (decode function_code), 11 I-type (decode opcode).
- opcode  in  6  instruction bits [31:26].
- function_code  in  6  instruction bits [5:0].
- shamt  in  5  instruction bits [10:6].
- A  in  32  rs operand.
- B  in  32  rt operand or extended immediate.
- pc_plus4  in  32  current PC + 4.
- branch_addr  in  32  branch target.
- jump_addr  in  32  J/JAL target.
- condition_met  in  1  branch taken.
- jump1  in  1  J/JAL.
- jump2  in  1  JR/JALR; the target is A.
- alu_ctrl_in  out  5  decoded operation code.
- alu_out  out  32  ALU result.
- zero  out  1  high when alu_out == 0.
- hi  out  32  multiply/divide HI result.
- lo  out  32  multiply/divide LO result.
- tgt_addr  out  32  combinational selected target.
- next_pc  out  32  value the PC loads next.
- redirect_pending  out  1  registered redirect flag.

Behaviour:
- ALU-control encoding (alu_ctrl_in):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU.
  - 8 SLL, 9 SRL, 10 SRA, 11 SLLV, 12 SRLV, 13 SRAV.
  - 14 MULT, 15 MULTU, 16 DIV, 17 DIVU, 18 LUI, 31 NOP.
- alu_op 00 -> ADD. alu_op 01 -> SUB.
- alu_op 10 decodes function_code:
  - 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU.
  - 0x00 SLL, 0x02 SRL, 0x03 SRA, 0x04 SLLV, 0x06 SRLV, 0x07 SRAV.
  - 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
  - Any other code (including JR/JALR, MFHI, MTHI) -> NOP.
- alu_op 11 decodes opcode:
  - 0x08/0x09 ADD, 0x0A SLT, 0x0B SLTU, 0x0C AND, 0x0D OR, 0x0E XOR, 0x0F LUI.
  - Any other opcode -> NOP.
- ADD/SUB wrap modulo 2^32; no overflow trap.
- SLT compares signed, SLTU unsigned; the result is 0 or 1.
- Fixed shifts operate on B by shamt. Variable shifts operate on B by A[4:0]. SRA replicates B[31].
- LUI: alu_out = {B[15:0], 16'h0}.
- NOP: alu_out = 0.
- hi/lo for non-mul/div operations are 0.
- MULT/MULTU: {hi,lo} = 64-bit signed/unsigned product of A and B. alu_out = 0.
- DIV/DIVU: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divisor 0: hi = lo = 0.
  - 0x80000000 / -1: lo = 0x80000000, hi = 0.
- zero is computed from alu_out.
- tgt_addr priority: jump2 -> A; else jump1 -> jump_addr; else condition_met -> branch_addr; else pc_plus4.
- Registered state, on posedge clk:
  - If reset: tgt_q = 0, redirect_pending = 0.
  - Else if clk_enable: tgt_q = tgt_addr, redirect_pending = jump1 | jump2 | condition_met.
  - Else: hold.
- next_pc = redirect_pending ? tgt_q : pc_plus4. This gives a one-instruction branch delay slot.
- A redirect issued in a delay slot is captured normally; the last redirect wins.
- Reset applied mid-redirect clears the pending flag, so next_pc = pc_plus4.
- All ALU paths are purely combinational, with zero latency.

Decomposition:
- Shared package mips_pkg holds:
  - alu_op_t (2-bit enum).
  - alu_ctrl_t (5-bit enum, values above).
  - The function-code and opcode localparams.
- One natural sub-module: mips_alu_decode, covering the alu_op/opcode/function_code -> alu_ctrl_in mapping.
- The ALU arithmetic, target selection and redirect register live in the top module.

Test Plan:
- R-type arithmetic:
  - alu_op=10, fn=0x23, A=5, B=7 -> alu_ctrl_in=1, alu_out=0xFFFFFFFE, zero=0.
  - fn=0x2A, A=0xFFFFFFFF, B=1 -> alu_out=1.
  - fn=0x2B, same operands -> alu_out=0.
- Shifts and LUI:
  - fn=0x03, shamt=4, B=0x80000000 -> alu_out=0xF8000000.
  - fn=0x04, A=33, B=1 -> alu_out=2.
  - alu_op=11, opcode=0x0F, B=0x1234 -> alu_out=0x12340000.
- Mul/div:
  - MULT A=-2, B=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - DIV A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU B=0 -> hi=lo=0.
- Branch compare: alu_op=01, A=B=0x55 -> zero=1.
- Redirect:
  - jump2=1, jump1=1, A=0x100 -> tgt_addr=0x100.
  - After the clock edge: redirect_pending=1 and next_pc=0x100. With no further redirect, the next cycle has next_pc=pc_plus4.
  - Untaken branch (condition_met=0) -> redirect_pending stays 0.
- Reset and hold:
  - Redirect pending then reset=1 -> redirect_pending=0, next_pc=pc_plus4.
  - clk_enable=0 during a jump -> redirect_pending unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and instruction-field encodings for the MIPS-I execute stage.
package mips_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_ITYPE = 2'b11
    } alu_op_t;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_AND   = 5'd2,
        ALU_OR    = 5'd3,
        ALU_XOR   = 5'd4,
        ALU_NOR   = 5'd5,
        ALU_SLT   = 5'd6,
        ALU_SLTU  = 5'd7,
        ALU_SLL   = 5'd8,
        ALU_SRL   = 5'd9,
        ALU_SRA   = 5'd10,
        ALU_SLLV  = 5'd11,
        ALU_SRLV  = 5'd12,
        ALU_SRAV  = 5'd13,
        ALU_MULT  = 5'd14,
        ALU_MULTU = 5'd15,
        ALU_DIV   = 5'd16,
        ALU_DIVU  = 5'd17,
        ALU_LUI   = 5'd18,
        ALU_NOP   = 5'd31
    } alu_ctrl_t;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

endpackage

// File: rtl/mips_exec_unit_if.sv
// Bundle between control/register-file side (master) and the execute stage (slave).
interface mips_exec_unit_if;
    import mips_pkg::*;

    alu_op_t     alu_op;
    logic [5:0]  opcode;
    logic [5:0]  function_code;
    logic [4:0]  shamt;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] pc_plus4;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic        condition_met;
    logic        jump1;
    logic        jump2;
    logic [4:0]  alu_ctrl_in;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] tgt_addr;
    logic [31:0] next_pc;
    logic        redirect_pending;

    modport master (
        output alu_op, opcode, function_code, shamt, A, B,
               pc_plus4, branch_addr, jump_addr, condition_met, jump1, jump2,
        input  alu_ctrl_in, alu_out, zero, hi, lo, tgt_addr, next_pc, redirect_pending
    );

    modport slave (
        input  alu_op, opcode, function_code, shamt, A, B,
               pc_plus4, branch_addr, jump_addr, condition_met, jump1, jump2,
        output alu_ctrl_in, alu_out, zero, hi, lo, tgt_addr, next_pc, redirect_pending
    );

endinterface

// File: rtl/mips_alu_decode.sv
// Maps alu_op plus opcode/function_code onto the ALU operation code.
module mips_alu_decode
    import mips_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] opcode,
    input  logic [5:0] function_code,
    output alu_ctrl_t  alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_NOP;
        case (alu_op)
            ALU_OP_ADD: alu_ctrl = ALU_ADD;
            ALU_OP_SUB: alu_ctrl = ALU_SUB;
            ALU_OP_RTYPE: begin
                case (function_code)
                    FN_ADD, FN_ADDU: alu_ctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
                    FN_AND:          alu_ctrl = ALU_AND;
                    FN_OR:           alu_ctrl = ALU_OR;
                    FN_XOR:          alu_ctrl = ALU_XOR;
                    FN_NOR:          alu_ctrl = ALU_NOR;
                    FN_SLT:          alu_ctrl = ALU_SLT;
                    FN_SLTU:         alu_ctrl = ALU_SLTU;
                    FN_SLL:          alu_ctrl = ALU_SLL;
                    FN_SRL:          alu_ctrl = ALU_SRL;
                    FN_SRA:          alu_ctrl = ALU_SRA;
                    FN_SLLV:         alu_ctrl = ALU_SLLV;
                    FN_SRLV:         alu_ctrl = ALU_SRLV;
                    FN_SRAV:         alu_ctrl = ALU_SRAV;
                    FN_MULT:         alu_ctrl = ALU_MULT;
                    FN_MULTU:        alu_ctrl = ALU_MULTU;
                    FN_DIV:          alu_ctrl = ALU_DIV;
                    FN_DIVU:         alu_ctrl = ALU_DIVU;
                    default:         alu_ctrl = ALU_NOP;
                endcase
            end
            ALU_OP_ITYPE: begin
                case (opcode)
                    OP_ADDI, OP_ADDIU: alu_ctrl = ALU_ADD;
                    OP_SLTI:           alu_ctrl = ALU_SLT;
                    OP_SLTIU:          alu_ctrl = ALU_SLTU;
                    OP_ANDI:           alu_ctrl = ALU_AND;
                    OP_ORI:            alu_ctrl = ALU_OR;
                    OP_XORI:           alu_ctrl = ALU_XOR;
                    OP_LUI:            alu_ctrl = ALU_LUI;
                    default:           alu_ctrl = ALU_NOP;
                endcase
            end
            default: alu_ctrl = ALU_NOP;
        endcase
    end

endmodule

// File: rtl/mips_exec_unit.sv
// Execute stage: ALU with HI/LO mul/div, next-PC target select, delay-slot redirect register.
module mips_exec_unit
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_enable,
    mips_exec_unit_if.slave bus
);

    alu_ctrl_t          ctrl;
    logic [31:0]        alu_res;
    logic [31:0]        hi_res;
    logic [31:0]        lo_res;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic               div_zero;
    logic               div_ovf;
    logic [31:0]        divisor_s;
    logic [31:0]        divisor_u;
    logic [31:0]        q_s, r_s, q_u, r_u;
    logic [31:0]        tgt_sel;
    logic [31:0]        tgt_q;
    logic               pending_q;

    mips_alu_decode u_decode (
        .alu_op        (bus.alu_op),
        .opcode        (bus.opcode),
        .function_code (bus.function_code),
        .alu_ctrl      (ctrl)
    );

    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'h0, bus.A} * {32'h0, bus.B};

    // Dividing by 1 in the overflow case yields exactly q=0x80000000, r=0,
    // and keeps the divider free of undefined operands.
    assign div_zero  = (bus.B == '0);
    assign div_ovf   = (bus.A == 32'h8000_0000) && (bus.B == '1);
    assign divisor_s = (div_zero || div_ovf) ? 32'd1 : bus.B;
    assign divisor_u = div_zero ? 32'd1 : bus.B;
    assign q_s = $signed(bus.A) / $signed(divisor_s);
    assign r_s = $signed(bus.A) % $signed(divisor_s);
    assign q_u = bus.A / divisor_u;
    assign r_u = bus.A % divisor_u;

    always_comb begin
        alu_res = '0;
        hi_res  = '0;
        lo_res  = '0;
        case (ctrl)
            ALU_ADD:   alu_res = bus.A + bus.B;
            ALU_SUB:   alu_res = bus.A - bus.B;
            ALU_AND:   alu_res = bus.A & bus.B;
            ALU_OR:    alu_res = bus.A | bus.B;
            ALU_XOR:   alu_res = bus.A ^ bus.B;
            ALU_NOR:   alu_res = ~(bus.A | bus.B);
            ALU_SLT:   alu_res = {31'h0, $signed(bus.A) < $signed(bus.B)};
            ALU_SLTU:  alu_res = {31'h0, bus.A < bus.B};
            ALU_SLL:   alu_res = bus.B << bus.shamt;
            ALU_SRL:   alu_res = bus.B >> bus.shamt;
            ALU_SRA:   alu_res = $signed(bus.B) >>> bus.shamt;
            ALU_SLLV:  alu_res = bus.B << bus.A[4:0];
            ALU_SRLV:  alu_res = bus.B >> bus.A[4:0];
            ALU_SRAV:  alu_res = $signed(bus.B) >>> bus.A[4:0];
            ALU_LUI:   alu_res = {bus.B[15:0], 16'h0};
            ALU_MULT:  {hi_res, lo_res} = prod_s;
            ALU_MULTU: {hi_res, lo_res} = prod_u;
            ALU_DIV: begin
                if (!div_zero) begin
                    lo_res = q_s;
                    hi_res = r_s;
                end
            end
            ALU_DIVU: begin
                if (!div_zero) begin
                    lo_res = q_u;
                    hi_res = r_u;
                end
            end
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        tgt_sel = bus.pc_plus4;
        if (bus.jump2)
            tgt_sel = bus.A;
        else if (bus.jump1)
            tgt_sel = bus.jump_addr;
        else if (bus.condition_met)
            tgt_sel = bus.branch_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_q     <= '0;
            pending_q <= 1'b0;
        end else if (clk_enable) begin
            tgt_q     <= tgt_sel;
            pending_q <= bus.jump1 | bus.jump2 | bus.condition_met;
        end
    end

    assign bus.alu_ctrl_in      = ctrl;
    assign bus.alu_out          = alu_res;
    assign bus.zero             = (alu_res == '0);
    assign bus.hi               = hi_res;
    assign bus.lo               = lo_res;
    assign bus.tgt_addr         = tgt_sel;
    assign bus.redirect_pending = pending_q;
    assign bus.next_pc          = pending_q ? tgt_q : bus.pc_plus4;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed self-checking bench for mips_exec_unit.
module tb_mips_exec_unit;
    import mips_pkg::*;

    logic clk;
    logic reset;
    logic clk_enable;
    int   n_cmp;
    int   n_err;

    mips_exec_unit_if bus ();

    mips_exec_unit dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_alu(input alu_op_t op, input logic [5:0] fn, input logic [5:0] opc,
                             input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.alu_op        = op;
        bus.function_code = fn;
        bus.opcode        = opc;
        bus.shamt         = sh;
        bus.A             = a;
        bus.B             = b;
        #1;
    endtask

    task automatic drive_ctl(input logic j1, input logic j2, input logic cm, input logic [31:0] pc4);
        @(negedge clk);
        bus.jump1         = j1;
        bus.jump2         = j2;
        bus.condition_met = cm;
        bus.pc_plus4      = pc4;
        #1;
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clk_enable = 1'b1;
        drive_ctl(1'b1, 1'b0, 1'b0, 32'h0000_0400);
        step_edge();
        n_cmp++; if (bus.redirect_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b want 0", bus.redirect_pending); end
        n_cmp++; if (bus.next_pc !== 32'h0000_0400) begin n_err++; $display("FAIL reset_next_pc: got %h want 00000400", bus.next_pc); end
        drive_ctl(1'b0, 1'b0, 1'b0, 32'h0000_0400);
        reset = 1'b0;
        step_edge();
    endtask

    task automatic test_rtype();
        drive_alu(ALU_OP_RTYPE, 6'h23, 6'h00, 5'd0, 32'd5, 32'd7);
        n_cmp++; if (bus.alu_ctrl_in !== 5'd1) begin n_err++; $display("FAIL subu_ctrl: got %0d want 1", bus.alu_ctrl_in); end
        n_cmp++; if (bus.alu_out !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL subu_out: got %h want fffffffe", bus.alu_out); end
        n_cmp++; if (bus.zero !== 1'b0) begin n_err++; $display("FAIL subu_zero: got %b want 0", bus.zero); end
        drive_alu(ALU_OP_RTYPE, 6'h2A, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1);
        n_cmp++; if (bus.alu_out !== 32'd1) begin n_err++; $display("FAIL slt_out: got %h want 00000001", bus.alu_out); end
        drive_alu(ALU_OP_RTYPE, 6'h2B, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1);
        n_cmp++; if (bus.alu_out !== 32'd0) begin n_err++; $display("FAIL sltu_out: got %h want 00000000", bus.alu_out); end
        drive_alu(ALU_OP_RTYPE, 6'h27, 6'h00, 5'd0, 32'h0F0F_0000, 32'h0000_00F0);
        n_cmp++; if (bus.alu_out !== 32'hF0F0_FF0F) begin n_err++; $display("FAIL nor_out: got %h want f0f0ff0f", bus.alu_out); end
        drive_alu(ALU_OP_RTYPE, 6'h08, 6'h00, 5'd0, 32'h1234, 32'h1);
        n_cmp++; if (bus.alu_ctrl_in !== 5'd31) begin n_err++; $display("FAIL jr_ctrl: got %0d want 31", bus.alu_ctrl_in); end
        n_cmp++; if (bus.alu_out !== 32'd0 || bus.zero !== 1'b1) begin n_err++; $display("FAIL nop_out: got %h/%b want 00000000/1", bus.alu_out, bus.zero); end
    endtask

    task automatic test_shift_lui();
        drive_alu(ALU_OP_RTYPE, 6'h03, 6'h00, 5'd4, 32'h0, 32'h8000_0000);
        n_cmp++; if (bus.alu_out !== 32'hF800_0000) begin n_err++; $display("FAIL sra_out: got %h want f8000000", bus.alu_out); end
        drive_alu(ALU_OP_RTYPE, 6'h02, 6'h00, 5'd4, 32'h0, 32'h8000_0000);
        n_cmp++; if (bus.alu_out !== 32'h0800_0000) begin n_err++; $display("FAIL srl_out: got %h want 08000000", bus.alu_out); end
        drive_alu(ALU_OP_RTYPE, 6'h04, 6'h00, 5'd0, 32'd33, 32'd1);
        n_cmp++; if (bus.alu_out !== 32'd2) begin n_err++; $display("FAIL sllv_out: got %h want 00000002", bus.alu_out); end
        drive_alu(ALU_OP_ITYPE, 6'h00, 6'h0F, 5'd0, 32'h0, 32'h0000_1234);
        n_cmp++; if (bus.alu_out !== 32'h1234_0000) begin n_err++; $display("FAIL lui_out: got %h want 12340000", bus.alu_out); end
        drive_alu(ALU_OP_ITYPE, 6'h00, 6'h09, 5'd0, 32'hFFFF_FFFF, 32'd2);
        n_cmp++; if (bus.alu_out !== 32'd1) begin n_err++; $display("FAIL addiu_wrap: got %h want 00000001", bus.alu_out); end
    endtask

    task automatic test_muldiv();
        drive_alu(ALU_OP_RTYPE, 6'h18, 6'h00, 5'd0, 32'hFFFF_FFFE, 32'd3);
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_hilo: got %h_%h want ffffffff_fffffffa", bus.hi, bus.lo); end
        n_cmp++; if (bus.alu_out !== 32'd0) begin n_err++; $display("FAIL mult_out: got %h want 00000000", bus.alu_out); end
        drive_alu(ALU_OP_RTYPE, 6'h19, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_cmp++; if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_hilo: got %h_%h want fffffffe_00000001", bus.hi, bus.lo); end
        drive_alu(ALU_OP_RTYPE, 6'h1A, 6'h00, 5'd0, 32'hFFFF_FFF9, 32'd2);
        n_cmp++; if (bus.lo !== 32'hFFFF_FFFD || bus.hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_qr: got lo=%h hi=%h want lo=fffffffd hi=ffffffff", bus.lo, bus.hi); end
        drive_alu(ALU_OP_RTYPE, 6'h1B, 6'h00, 5'd0, 32'd100, 32'd0);
        n_cmp++; if (bus.lo !== 32'd0 || bus.hi !== 32'd0) begin n_err++; $display("FAIL divu_zero: got lo=%h hi=%h want 0/0", bus.lo, bus.hi); end
        drive_alu(ALU_OP_RTYPE, 6'h1A, 6'h00, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'd0) begin n_err++; $display("FAIL div_ovf: got lo=%h hi=%h want 80000000/0", bus.lo, bus.hi); end
        drive_alu(ALU_OP_RTYPE, 6'h1B, 6'h00, 5'd0, 32'hFFFF_FFF9, 32'd2);
        n_cmp++; if (bus.lo !== 32'h7FFF_FFFC || bus.hi !== 32'd1) begin n_err++; $display("FAIL divu_qr: got lo=%h hi=%h want 7ffffffc/1", bus.lo, bus.hi); end
        drive_alu(ALU_OP_RTYPE, 6'h20, 6'h00, 5'd0, 32'd4, 32'd5);
        n_cmp++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.alu_out !== 32'd9) begin n_err++; $display("FAIL add_hilo: got hi=%h lo=%h out=%h want 0/0/9", bus.hi, bus.lo, bus.alu_out); end
    endtask

    task automatic test_branch_compare();
        drive_alu(ALU_OP_SUB, 6'h00, 6'h04, 5'd0, 32'h55, 32'h55);
        n_cmp++; if (bus.zero !== 1'b1 || bus.alu_ctrl_in !== 5'd1) begin n_err++; $display("FAIL beq_zero: got zero=%b ctrl=%0d want 1/1", bus.zero, bus.alu_ctrl_in); end
        drive_alu(ALU_OP_ADD, 6'h00, 6'h23, 5'd0, 32'h1000, 32'h10);
        n_cmp++; if (bus.alu_out !== 32'h1010 || bus.zero !== 1'b0) begin n_err++; $display("FAIL lw_addr: got %h/%b want 00001010/0", bus.alu_out, bus.zero); end
    endtask

    task automatic test_redirect();
        bus.A           = 32'h0000_0100;
        bus.jump_addr   = 32'h0000_0200;
        bus.branch_addr = 32'h0000_0300;
        drive_ctl(1'b1, 1'b1, 1'b0, 32'h0000_0404);
        n_cmp++; if (bus.tgt_addr !== 32'h0000_0100) begin n_err++; $display("FAIL jr_tgt: got %h want 00000100", bus.tgt_addr); end
        step_edge();
        n_cmp++; if (bus.redirect_pending !== 1'b1 || bus.next_pc !== 32'h0000_0100) begin n_err++; $display("FAIL jr_redirect: got %b/%h want 1/00000100", bus.redirect_pending, bus.next_pc); end
        drive_ctl(1'b0, 1'b0, 1'b0, 32'h0000_0108);
        step_edge();
        n_cmp++; if (bus.redirect_pending !== 1'b0 || bus.next_pc !== 32'h0000_0108) begin n_err++; $display("FAIL after_slot: got %b/%h want 0/00000108", bus.redirect_pending, bus.next_pc); end
        drive_ctl(1'b0, 1'b0, 1'b0, 32'h0000_010C);
        n_cmp++; if (bus.tgt_addr !== 32'h0000_010C) begin n_err++; $display("FAIL untaken_tgt: got %h want 0000010c", bus.tgt_addr); end
        step_edge();
        n_cmp++; if (bus.redirect_pending !== 1'b0) begin n_err++; $display("FAIL untaken_pending: got %b want 0", bus.redirect_pending); end
        drive_ctl(1'b0, 1'b0, 1'b1, 32'h0000_0110);
        step_edge();
        n_cmp++; if (bus.next_pc !== 32'h0000_0300) begin n_err++; $display("FAIL branch_next_pc: got %h want 00000300", bus.next_pc); end
        drive_ctl(1'b1, 1'b0, 1'b0, 32'h0000_0114);
        n_cmp++; if (bus.tgt_addr !== 32'h0000_0200) begin n_err++; $display("FAIL j_tgt: got %h want 00000200", bus.tgt_addr); end
        step_edge();
        n_cmp++; if (bus.redirect_pending !== 1'b1 || bus.next_pc !== 32'h0000_0200) begin n_err++; $display("FAIL slot_redirect: got %b/%h want 1/00000200", bus.redirect_pending, bus.next_pc); end
        drive_ctl(1'b0, 1'b0, 1'b0, 32'h0000_0204);
        step_edge();
    endtask

    task automatic test_reset_hold();
        drive_ctl(1'b1, 1'b0, 1'b0, 32'h0000_0500);
        step_edge();
        drive_ctl(1'b1, 1'b0, 1'b0, 32'h0000_0504);
        reset = 1'b1;
        step_edge();
        n_cmp++; if (bus.redirect_pending !== 1'b0 || bus.next_pc !== 32'h0000_0504) begin n_err++; $display("FAIL mid_reset: got %b/%h want 0/00000504", bus.redirect_pending, bus.next_pc); end
        drive_ctl(1'b1, 1'b0, 1'b0, 32'h0000_0508);
        reset = 1'b0;
        clk_enable = 1'b0;
        step_edge();
        n_cmp++; if (bus.redirect_pending !== 1'b0 || bus.next_pc !== 32'h0000_0508) begin n_err++; $display("FAIL hold_idle: got %b/%h want 0/00000508", bus.redirect_pending, bus.next_pc); end
        clk_enable = 1'b1;
        step_edge();
        drive_ctl(1'b0, 1'b0, 1'b0, 32'h0000_0600);
        clk_enable = 1'b0;
        step_edge();
        n_cmp++; if (bus.redirect_pending !== 1'b1 || bus.next_pc !== 32'h0000_0200) begin n_err++; $display("FAIL hold_pending: got %b/%h want 1/00000200", bus.redirect_pending, bus.next_pc); end
        clk_enable = 1'b1;
        step_edge();
        n_cmp++; if (bus.redirect_pending !== 1'b0 || bus.next_pc !== 32'h0000_0600) begin n_err++; $display("FAIL release: got %b/%h want 0/00000600", bus.redirect_pending, bus.next_pc); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        clk_enable = 1'b1;
        bus.alu_op        = ALU_OP_ADD;
        bus.opcode        = '0;
        bus.function_code = '0;
        bus.shamt         = '0;
        bus.A             = '0;
        bus.B             = '0;
        bus.pc_plus4      = '0;
        bus.branch_addr   = '0;
        bus.jump_addr     = '0;
        bus.condition_met = 1'b0;
        bus.jump1         = 1'b0;
        bus.jump2         = 1'b0;

        test_reset();
        test_rtype();
        test_shift_lui();
        test_muldiv();
        test_branch_compare();
        test_redirect();
        test_reset_hold();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
